// File: rtl/microsequencer.sv
// Clocked microinstruction sequencer: owns the T-state counter, decodes the 16-bit
// microinstruction into bus strobes, latches ALU flags and stalls on device transfers.
module microsequencer #(
    parameter int TSTEP_BITS  = 3,
    parameter int OPCODE_BITS = 8,
    parameter bit DEV_STALL   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [OPCODE_BITS-1:0]            opcode,
    input  logic [15:0]                       uinstr,
    input  logic                              alu_z,
    input  logic                              alu_lt,
    input  logic                              alu_c,
    input  logic                              dev_ready,
    output logic [OPCODE_BITS+TSTEP_BITS-1:0] uaddr,
    output logic [TSTEP_BITS-1:0]             tstate,
    output logic [7:0]                        out_en,
    output logic                              eo,
    output logic [5:0]                        alu_flags,
    output logic                              ce,
    output logic [7:0]                        in_en,
    output logic                              pc_inc,
    output logic                              jump,
    output logic                              dev_req,
    output logic [2:0]                        flags_q
);

    localparam logic [2:0] DEV_CODE = 3'd6;

    logic [TSTEP_BITS-1:0] tstate_q, tstate_d;
    logic [2:0]            flags_d;
    logic [2:0]            bus_out, bus_in;
    logic                  rt, dev_out, dev_in, stall, live, gt;
    logic                  unused_bit0;

    assign unused_bit0 = uinstr[0];

    // Field decode; which meaning a shared bit carries depends on eo.
    assign eo        = ~uinstr[15];
    assign bus_out   = uinstr[14:12];
    assign bus_in    = uinstr[7:5];
    assign alu_flags = uinstr[14:9];
    assign rt        = ~eo & uinstr[11];

    assign dev_out = ~eo & (bus_out == DEV_CODE);
    assign dev_in  = bus_in == DEV_CODE;
    assign dev_req = DEV_STALL & (dev_out | dev_in) & ~reset;
    assign stall   = dev_req & ~dev_ready;

    // Strobes fire only when the sequencer is actually going to advance.
    assign live = ~reset & ~stall;

    always_comb begin
        out_en = '0;
        if (!eo) begin
            out_en[bus_out] = 1'b1;
        end
    end

    always_comb begin
        in_en = '0;
        if (live && bus_in != 3'd0) begin
            in_en[bus_in] = 1'b1;
        end
    end

    assign ce     = live & eo & uinstr[8];
    assign pc_inc = live & ~eo & uinstr[10];

    // Jumps test the flags latched before this edge, never the live ALU outputs.
    assign gt   = ~flags_q[2] & ~flags_q[1];
    assign jump = live & ((uinstr[4] & flags_q[2]) | (uinstr[3] & gt) |
                          (uinstr[2] & flags_q[1]) | (uinstr[1] & flags_q[0]));

    always_comb begin
        tstate_d = tstate_q;
        flags_d  = flags_q;
        if (!stall) begin
            if (rt || tstate_q == '1) begin
                tstate_d = '0;
            end else begin
                tstate_d = tstate_q + TSTEP_BITS'(1);
            end
        end
        if (ce) begin
            flags_d = {alu_z, alu_lt, alu_c};
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous here.
    always_ff @(posedge clk) begin
        if (reset) begin
            tstate_q <= '0;
            flags_q  <= '0;
        end else begin
            tstate_q <= tstate_d;
            flags_q  <= flags_d;
        end
    end

    assign tstate = tstate_q;
    assign uaddr  = {opcode, tstate_q};

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: a decode vector table plus hand-written
// sequences for counter wrap, RT, flag latching, device stalls and reset.
module tb_microsequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  opcode;
    logic [15:0] uinstr;
    logic        alu_z, alu_lt, alu_c, dev_ready;

    logic [10:0] uaddr, uaddr_n;
    logic [2:0]  tstate, tstate_n, flags_q, flags_n;
    logic [7:0]  out_en, out_en_n, in_en, in_en_n;
    logic [5:0]  alu_flags, alu_flags_n;
    logic        eo, eo_n, ce, ce_n, pc_inc, pc_inc_n, jump, jump_n, dev_req, dev_req_n;

    int total = 0;
    int bad   = 0;

    microsequencer #(.TSTEP_BITS(3), .OPCODE_BITS(8), .DEV_STALL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .uinstr(uinstr),
        .alu_z(alu_z), .alu_lt(alu_lt), .alu_c(alu_c), .dev_ready(dev_ready),
        .uaddr(uaddr), .tstate(tstate), .out_en(out_en), .eo(eo),
        .alu_flags(alu_flags), .ce(ce), .in_en(in_en), .pc_inc(pc_inc),
        .jump(jump), .dev_req(dev_req), .flags_q(flags_q)
    );

    microsequencer #(.TSTEP_BITS(3), .OPCODE_BITS(8), .DEV_STALL(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .opcode(opcode), .uinstr(uinstr),
        .alu_z(alu_z), .alu_lt(alu_lt), .alu_c(alu_c), .dev_ready(dev_ready),
        .uaddr(uaddr_n), .tstate(tstate_n), .out_en(out_en_n), .eo(eo_n),
        .alu_flags(alu_flags_n), .ce(ce_n), .in_en(in_en_n), .pc_inc(pc_inc_n),
        .jump(jump_n), .dev_req(dev_req_n), .flags_q(flags_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ui;
        logic [7:0]  out_en;
        logic        eo;
        logic [5:0]  alu_flags;
        logic        ce;
        logic [7:0]  in_en;
        logic        pc_inc;
        logic        jump;
        logic        dev_req;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Decode table, applied with flags_q == 0 (so only JGT can jump) and dev_ready high.
        vecs[0] = '{16'h8020, 8'h01, 1'b0, 6'h00, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h9400, 8'h02, 1'b0, 6'h0A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'hF0E0, 8'h80, 1'b0, 6'h38, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8008, 8'h01, 1'b0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8016, 8'h01, 1'b0, 6'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h7E00, 8'h00, 1'b1, 6'h3F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0300, 8'h00, 1'b1, 6'h01, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8A40, 8'h01, 1'b0, 6'h05, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h80C0, 8'h01, 1'b0, 6'h00, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{16'h0C00, 8'h00, 1'b1, 6'h06, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; opcode = 8'h5A; uinstr = 16'h8020;
        alu_z = 1'b0; alu_lt = 1'b0; alu_c = 1'b0; dev_ready = 1'b1;
        tick(); tick();
        check("reset_in_en", in_en, 8'h00);
        check("reset_tstate", tstate, 3'd0);
        check("reset_flags", flags_q, 3'b000);
        check("reset_uaddr", uaddr, {8'h5A, 3'd0});

        reset = 1'b0; #1;
        check("rel_in_en", in_en, 8'h02);
        check("rel_out_en", out_en, 8'h01);
        check("rel_tstate", tstate, 3'd0);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("step_tstate", tstate, 32'(i % 8));
        end
        tick(); tick();
        check("pre_rt_tstate", tstate, 3'd3);
        uinstr = 16'h8800; #1;
        check("rt_uaddr", uaddr, {8'h5A, 3'd3});
        tick();
        check("rt_tstate", tstate, 3'd0);

        for (int v = 0; v < 10; v++) begin
            uinstr = vecs[v].ui; #1;
            check("vec_out_en", out_en, vecs[v].out_en);
            check("vec_eo", eo, vecs[v].eo);
            check("vec_alu_flags", alu_flags, vecs[v].alu_flags);
            check("vec_ce", ce, vecs[v].ce);
            check("vec_in_en", in_en, vecs[v].in_en);
            check("vec_pc_inc", pc_inc, vecs[v].pc_inc);
            check("vec_jump", jump, vecs[v].jump);
            check("vec_dev_req", dev_req, vecs[v].dev_req);
            tick();
        end

        // Flag latching and jumps on latched flags.
        uinstr = 16'h0100; alu_z = 1'b1; #1;
        check("alu_ce", ce, 1'b1);
        tick();
        check("flags_z", flags_q, 3'b100);
        uinstr = 16'h8010; alu_z = 1'b0; #1;
        check("jz_taken", jump, 1'b1);
        uinstr = 16'h8008; #1;
        check("jgt_not_taken", jump, 1'b0);
        tick();
        uinstr = 16'h0100; alu_lt = 1'b1; alu_c = 1'b1; tick();
        check("flags_lt_c", flags_q, 3'b011);
        uinstr = 16'h8004; #1;
        check("jlt_taken", jump, 1'b1);
        uinstr = 16'h8002; #1;
        check("jc_taken", jump, 1'b1);
        uinstr = 16'h8010; #1;
        check("jz_not_taken", jump, 1'b0);
        tick();

        // ce and JZ in the same cycle: jump sees the old flags.
        uinstr = 16'h0100; alu_lt = 1'b0; alu_c = 1'b0; tick();
        check("flags_clear", flags_q, 3'b000);
        uinstr = 16'h0110; alu_z = 1'b1; #1;
        check("same_cycle_jump", jump, 1'b0);
        tick();
        check("same_cycle_flags", flags_q, 3'b100);
        alu_z = 1'b0; #1;
        check("next_cycle_jump", jump, 1'b1);
        tick();
        check("next_cycle_flags", flags_q, 3'b000);

        reset = 1'b1; uinstr = 16'h8000; tick();
        reset = 1'b0; #1;
        check("rst2_tstate", tstate, 3'd0);
        check("rst2_tstate_ns", tstate_n, 3'd0);
        tick();

        // Device out with P+ and JGT: three stalled cycles, then the ready cycle.
        uinstr = 16'hE408; dev_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("dout_dev_req", dev_req, 1'b1);
            check("dout_out_en", out_en, 8'h40);
            check("dout_pc_inc", pc_inc, 1'b0);
            check("dout_jump", jump, 1'b0);
            check("dout_ns_dev_req", dev_req_n, 1'b0);
            check("dout_ns_jump", jump_n, 1'b1);
            tick();
            check("dout_hold_tstate", tstate, 3'd1);
            check("dout_ns_tstate", tstate_n, 32'(2 + k));
        end
        dev_ready = 1'b1; #1;
        check("dout_rdy_dev_req", dev_req, 1'b1);
        check("dout_rdy_pc_inc", pc_inc, 1'b1);
        check("dout_rdy_jump", jump, 1'b1);
        tick();
        check("dout_adv_tstate", tstate, 3'd2);
        check("dout_adv_ns_tstate", tstate_n, 3'd5);

        // Device in on an ALU op: flags hold while stalled.
        uinstr = 16'h01C0; alu_z = 1'b1; dev_ready = 1'b0; #1;
        check("din_ce_stall", ce, 1'b0);
        check("din_in_en_stall", in_en, 8'h00);
        check("din_ns_in_en", in_en_n, 8'h40);
        tick();
        check("din_flags_hold", flags_q, 3'b000);
        check("din_ns_flags", flags_n, 3'b100);
        check("din_tstate_hold", tstate, 3'd2);
        dev_ready = 1'b1; #1;
        check("din_ce_rdy", ce, 1'b1);
        check("din_in_en_rdy", in_en, 8'h40);
        tick();
        check("din_flags_load", flags_q, 3'b100);
        check("din_tstate_adv", tstate, 3'd3);
        check("din_ns_tstate", tstate_n, 3'd7);

        uinstr = 16'h8000; alu_z = 1'b0; tick();
        check("pre_abort_tstate", tstate, 3'd4);
        check("ns_wrap_tstate", tstate_n, 3'd0);

        // Reset during a stalled device-in abandons the transfer.
        uinstr = 16'h80C0; dev_ready = 1'b0; #1;
        check("abort_dev_req", dev_req, 1'b1);
        check("abort_in_en", in_en, 8'h00);
        tick();
        check("abort_hold_tstate", tstate, 3'd4);
        reset = 1'b1; dev_ready = 1'b1; #1;
        check("abort_rst_in_en", in_en, 8'h00);
        tick();
        check("abort_rst_tstate", tstate, 3'd0);
        check("abort_rst_flags", flags_q, 3'b000);
        reset = 1'b0; uinstr = 16'h8000; #1;
        check("abort_rel_tstate", tstate, 3'd0);
        check("abort_rel_in_en", in_en, 8'h00);
        tick();
        check("abort_step_tstate", tstate, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Clocked successor to the combinational microinstruction decoder.
- Owns the T-state counter and forms the microcode address {opcode, tstate}.
- Decodes the 16-bit microinstruction into one-hot bus enables, latches ALU flags, and evaluates conditional jumps against the latched flags.
- Stalls on device transfers until a ready handshake arrives.
- Sits between the IR/microcode ROM and the datapath.

Parameters:
- TSTEP_BITS, 3, T-state counter width; steps per instruction = 2**TSTEP_BITS.
- OPCODE_BITS, 8, opcode width; taken from IR high byte.
- DEV_STALL, 1, 1 = device transfers wait for dev_ready; 0 = never stall.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_BITS  current IR high byte.
- uinstr  in  16  microinstruction from combinational-read ROM at uaddr, same cycle.
- alu_z, alu_lt, alu_c  in  1 each  live ALU zero/negative/carry.
- dev_ready  in  1  device completed the transfer this cycle.
- uaddr  out  OPCODE_BITS+TSTEP_BITS  {opcode, tstate}.
- tstate  out  TSTEP_BITS  current step.
- out_en  out  8  one-hot bus driver enable (index = bus_out code); all 0 when ALU drives.
- eo  out  1  ALU drives bus.
- alu_flags  out  6  uinstr[14:9].
- ce  out  1  uinstr[8] when eo, else 0.
- in_en  out  8  one-hot bus load strobe (index = bus_in code); bit 0 always 0.
- pc_inc  out  1  P+ strobe.
- jump  out  1  load PC from bus this cycle.
- dev_req  out  1  device transfer in progress.
- flags_q  out  3  latched {z, lt, c}.

Behaviour:
- uinstr layout:
  - [15] = !EO.
  - [14:12] = EO ? EX/NX/EY : bus_out code.
  - [11] = EO ? NY : RT.
  - [10] = EO ? F : P+.
  - [9] = NO when EO.
  - [8] = CE when EO.
  - [7:5] = bus_in code.
  - [4:1] = JZ, JGT, JLT, JC.
  - [0] unused.
- Decode is combinational from uinstr:
  - eo = !uinstr[15].
  - out_en[k] = !eo && bus_out==k.
  - RT and P+ are valid only when !eo.
- Device codes:
  - Device out is bus_out==6.
  - Device in is bus_in==6.
  - dev_req = DEV_STALL && (device out || device in).
- stall = dev_req && !dev_ready.
- While stalled:
  - tstate, flags_q and opcode use are held.
  - in_en, pc_inc, jump and ce are forced to 0.
  - out_en, eo and alu_flags remain driven.
- On the dev_ready cycle, strobes fire normally and the sequencer advances.
- tstate next value, first matching rule applies:
  - reset -> 0.
  - stall -> hold.
  - RT (uinstr[11] && !eo) -> 0.
  - tstate == max -> 0 (wrap; no error).
  - otherwise tstate+1.
- flags_q update:
  - Loads {alu_z, alu_lt, alu_c} on every non-stalled cycle with eo=1 and ce=1.
  - Otherwise held.
- Jump evaluation:
  - gt = !flags_q.z && !flags_q.lt.
  - jump = !stall && ((JZ&&z_q) || (JGT&&gt) || (JLT&&lt_q) || (JC&&c_q)).
  - Jump uses flags_q as latched before this edge, never live ALU flags, so same-cycle compare-and-jump sees the previous result.
- in_en[k] = !stall && bus_in==k for k=1..7.
- Simultaneous events:
  - RT with jump: both take effect.
  - RT with stall: stall wins and RT is applied on the ready cycle.
  - ce with a jump bit: jump uses the old flags, flags_q takes the new.
- Reset values:
  - tstate=0, flags_q=0, uaddr={opcode,0}.
  - All strobes derive from uinstr but are gated to 0 while reset is high.
  - A reset asserted mid-stall abandons the transfer.
- Latency:
  - Decode outputs: 0 cycles from uinstr.
  - tstate/flags: 1 cycle.

Test Plan:
- Reset with uinstr=0x8020, then release -> during reset in_en=0, tstate=0; after release in_en[1]=1, out_en[0]=1, and tstate steps 0,1,2,... wrapping 7->0.
- uinstr=0x8800 (RT, !eo) at tstate=3 -> next tstate=0.
- ALU op uinstr=0x0100 with alu_z=1 then uinstr=0x8010 (JZ) -> flags_q=3'b100 after the first edge; jump=1 on the second cycle.
- Same-cycle uinstr=0x0110 (ce+JZ), flags_q=0, alu_z=1 -> jump=0 that cycle; flags_q.z=1 after the edge.
- uinstr=0xE000 (device out), dev_ready low 3 cycles then high -> dev_req=1 for 4 cycles, tstate held 3 cycles, out_en[6] held; advances on the 4th. Repeat with DEV_STALL=0 -> no hold.
- Device in uinstr=0x80C0 stalled at tstate=4, reset pulsed -> tstate=0, in_en=0, no device load.
